// File: rtl/colparity_pkg.sv
// Shared definitions for the column-parity slice frame buffer:
// default geometry, per-bank state encoding and the wrapped-index helper.
package colparity_pkg;

    localparam int unsigned COLPARITY_W     = 25;
    localparam int unsigned COLPARITY_DEPTH = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // (idx - 1) mod depth; depth must be a power of two so index 0 wraps to depth-1
    function automatic int unsigned wrap_dec(input int unsigned idx, input int unsigned depth);
        return (idx + depth - 1) & (depth - 1);
    endfunction

endpackage

// File: rtl/slice_bank_ram.sv
// One DEPTH x W slice bank: synchronous write port and registered read port(s).
// The neighbour read port exists only when COLPARITY_FB_DUAL_RD_EN is defined.
// Storage is not reset; only the read registers are.
module slice_bank_ram
    import colparity_pkg::*;
#(
    parameter int unsigned  W     = COLPARITY_W,
    parameter int unsigned  DEPTH = COLPARITY_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
`ifdef COLPARITY_FB_DUAL_RD_EN
    input  logic [AW-1:0] raddr_nb_i,
    output logic [W-1:0]  rdata_nb_o,
`endif
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Slice storage write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered primary read; holds its value when not enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef COLPARITY_FB_DUAL_RD_EN
    logic [W-1:0] rdata_nb_q;

    // Registered neighbour read, enabled together with the primary port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_nb_q <= '0;
        end else if (re_i) begin
            rdata_nb_q <= mem_q[raddr_nb_i];
        end
    end

    assign rdata_nb_o = rdata_nb_q;
`endif

endmodule

// File: rtl/slice_frame_buffer.sv
// Double-buffered (ping-pong) store of Keccak state frames organised as
// DEPTH slices of W bits. A producer fills the write bank in slice order
// while the column-parity datapath reads the other bank by slice index.
// Optional feature macro: COLPARITY_FB_DUAL_RD_EN (adds rd_data_nb, a second
// read port returning the wrapped neighbour slice alongside rd_data).
module slice_frame_buffer
    import colparity_pkg::*;
#(
    parameter int unsigned  W     = COLPARITY_W,
    parameter int unsigned  DEPTH = COLPARITY_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_req,
    input  logic          rd_sel,
    input  logic [AW-1:0] rd_idx,
    input  logic          rd_release,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
`ifdef COLPARITY_FB_DUAL_RD_EN
    output logic [W-1:0]  rd_data_nb,
`endif
    output logic          frame_avail,
    output logic [1:0]    frames_stored
);

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          rd_bank_q, rd_bank_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_ready_q, wr_ready_d;
    logic          frame_avail_q, frame_avail_d;
    logic [1:0]    frames_stored_q, frames_stored_d;

    logic          wr_fire_c;
    logic          rd_fire_c;
    logic          rel_fire_c;
    logic [AW-1:0] rd_addr_c;
    logic [AW-1:0] rd_addr_nb_c;
    logic [W-1:0]  bank_rdata [2];
`ifdef COLPARITY_FB_DUAL_RD_EN
    logic [W-1:0]  bank_rdata_nb [2];
`endif

    assign wr_fire_c  = wr_valid && wr_ready_q;
    assign rd_fire_c  = rd_req && frame_avail_q;
    assign rel_fire_c = rd_release && (bank_q[rb_q] == FULL);

    // Neighbour address always wraps within AW bits so slice 0 maps to DEPTH-1
    assign rd_addr_nb_c = AW'(wrap_dec(32'(rd_idx), DEPTH));

`ifdef COLPARITY_FB_DUAL_RD_EN
    logic unused_rd_sel;
    assign unused_rd_sel = rd_sel;
    assign rd_addr_c     = rd_idx;
`else
    assign rd_addr_c     = rd_sel ? rd_addr_nb_c : rd_idx;
`endif

    // Bank-state and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_q[0]       <= EMPTY;
            bank_q[1]       <= EMPTY;
            wb_q            <= 1'b0;
            rb_q            <= 1'b0;
            wr_ptr_q        <= '0;
            rd_bank_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            wr_ready_q      <= 1'b1;
            frame_avail_q   <= 1'b0;
            frames_stored_q <= 2'd0;
        end else begin
            bank_q          <= bank_d;
            wb_q            <= wb_d;
            rb_q            <= rb_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_bank_q       <= rd_bank_d;
            rd_valid_q      <= rd_valid_d;
            wr_ready_q      <= wr_ready_d;
            frame_avail_q   <= frame_avail_d;
            frames_stored_q <= frames_stored_d;
        end
    end

    // Next-state: write fill, frame completion, release, and derived status flags
    always_comb begin
        bank_d     = bank_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        wr_ptr_d   = wr_ptr_q;
        rd_bank_d  = rd_bank_q;
        rd_valid_d = rd_fire_c;

        if (wr_fire_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
                bank_d[wb_q] = FULL;
                wb_d         = ~wb_q;
            end else begin
                bank_d[wb_q] = FILLING;
            end
        end

        // A FULL bank is never the write target, so this never collides with the write above
        if (rel_fire_c) begin
            bank_d[rb_q] = EMPTY;
            rb_d         = ~rb_q;
        end

        // Read is served from the bank that was current before any same-cycle release
        if (rd_fire_c) begin
            rd_bank_d = rb_q;
        end

        wr_ready_d      = (bank_d[wb_d] != FULL);
        frame_avail_d   = (bank_d[rb_d] == FULL);
        frames_stored_d = 2'(bank_d[0] == FULL) + 2'(bank_d[1] == FULL);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        slice_bank_ram #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk        (clk),
            .rst_n      (rst),
            .we_i       (wr_fire_c && (wb_q == 1'(b))),
            .waddr_i    (wr_ptr_q),
            .wdata_i    (wr_data),
            .re_i       (rd_fire_c && (rb_q == 1'(b))),
            .raddr_i    (rd_addr_c),
`ifdef COLPARITY_FB_DUAL_RD_EN
            .raddr_nb_i (rd_addr_nb_c),
            .rdata_nb_o (bank_rdata_nb[b]),
`endif
            .rdata_o    (bank_rdata[b])
        );
    end

`ifndef COLPARITY_FB_DUAL_RD_EN
    logic [AW-1:0] unused_addr_nb;
    assign unused_addr_nb = rd_addr_nb_c;
`endif

    assign rd_data       = bank_rdata[rd_bank_q];
`ifdef COLPARITY_FB_DUAL_RD_EN
    assign rd_data_nb    = bank_rdata_nb[rd_bank_q];
`endif
    assign rd_valid      = rd_valid_q;
    assign wr_ready      = wr_ready_q;
    assign frame_avail   = frame_avail_q;
    assign frames_stored = frames_stored_q;

endmodule

// File: tb/tb_slice_frame_buffer.sv
// Scoreboard bench for slice_frame_buffer: reads push expected slices into a
// queue, a negedge monitor pops and compares whenever rd_valid is high.
module tb_slice_frame_buffer;

    localparam int unsigned W  = 25;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [W-1:0]  wr_data;
    logic          rd_req;
    logic          rd_sel;
    logic [AW-1:0] rd_idx;
    logic          rd_release;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
`ifdef COLPARITY_FB_DUAL_RD_EN
    logic [W-1:0]  rd_data_nb;
`endif
    logic          frame_avail;
    logic [1:0]    frames_stored;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] nb;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    slice_frame_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_req        (rd_req),
        .rd_sel        (rd_sel),
        .rd_idx        (rd_idx),
        .rd_release    (rd_release),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
`ifdef COLPARITY_FB_DUAL_RD_EN
        .rd_data_nb    (rd_data_nb),
`endif
        .frame_avail   (frame_avail),
        .frames_stored (frames_stored)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read result must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid with no pending read, rd_data %0d", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.d) begin
                    errors++;
                    $display("FAIL rd_data: got %0d expected %0d at %0t", rd_data, e.d, $time);
                end
`ifdef COLPARITY_FB_DUAL_RD_EN
                checks++;
                if (rd_data_nb !== e.nb) begin
                    errors++;
                    $display("FAIL rd_data_nb: got %0d expected %0d at %0t", rd_data_nb, e.nb, $time);
                end
`endif
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_valid"},      32'(rd_valid),      0);
        chk({tag, "_rd_data"},       32'(rd_data),       0);
        chk({tag, "_frame_avail"},   32'(frame_avail),   0);
        chk({tag, "_frames_stored"}, 32'(frames_stored), 0);
        chk({tag, "_wr_ready"},      32'(wr_ready),      1);
`ifdef COLPARITY_FB_DUAL_RD_EN
        chk({tag, "_rd_data_nb"},    32'(rd_data_nb),    0);
`endif
    endtask

    // Stream n slices (base+i); for a complete frame, optionally check that
    // frame_avail is still low while the last slice is offered and high after
    task automatic write_frame(input int base, input int n, input bit check_rise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) chk("wr_ready_start", 32'(wr_ready), 1);
            if (check_rise && i == 63) chk("frame_avail_before_last", 32'(frame_avail), 0);
            wr_valid = 1'b1;
            wr_data  = W'(base + i);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        if (n == 64) chk("frame_avail_after_last", 32'(frame_avail), 1);
    endtask

    // Single-cycle read request; e_sel is the single-port result, e_main/e_nb the dual-port pair
    task automatic do_read(input int idx, input bit sel, input int e_sel, input int e_main,
                           input int e_nb, input bit rel);
        exp_t e;
        @(negedge clk);
        rd_req     = 1'b1;
        rd_idx     = AW'(idx);
        rd_sel     = sel;
        rd_release = rel;
`ifdef COLPARITY_FB_DUAL_RD_EN
        e.d  = W'(e_main);
        e.nb = W'(e_nb);
`else
        e.d  = W'(e_sel);
        e.nb = W'(e_nb);
`endif
        exp_q.push_back(e);
        @(negedge clk);
        rd_req     = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic do_release();
        @(negedge clk);
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_req     = 1'b0;
        rd_sel     = 1'b0;
        rd_idx     = '0;
        rd_release = 1'b0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        // Read and release with no complete frame are ignored
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = AW'(5);
        @(negedge clk);
        rd_req = 1'b0;
        chk("idle_read_rd_valid", 32'(rd_valid), 0);
        do_release();
        chk("idle_rel_frames_stored", 32'(frames_stored), 0);
        chk("idle_rel_wr_ready",      32'(wr_ready),      1);
        chk("idle_rel_frame_avail",   32'(frame_avail),   0);

        // Frame A: slice i = i
        write_frame(0, 64, 1'b1);
        chk("a_frames_stored", 32'(frames_stored), 1);
        do_read(5,  1'b0, 5,  5,  4,  1'b0);
        do_read(0,  1'b1, 63, 0,  63, 1'b0);
        do_read(63, 1'b1, 62, 63, 62, 1'b0);

        // Frame B: slice i = i + 100 fills the second bank
        write_frame(100, 64, 1'b0);
        chk("ab_frames_stored", 32'(frames_stored), 2);
        chk("ab_wr_ready",      32'(wr_ready),      0);
        chk("ab_frame_avail",   32'(frame_avail),   1);

        // Write offered while both banks are full must not be taken
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = W'(999);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("blocked_frames_stored", 32'(frames_stored), 2);
        chk("blocked_wr_ready",      32'(wr_ready),      0);

        // Read from A, then read + release in the same cycle still returns A
        do_read(3, 1'b0, 3, 3, 2, 1'b0);
        do_read(7, 1'b0, 7, 7, 6, 1'b1);
        chk("rel_wr_ready",      32'(wr_ready),      1);
        chk("rel_frames_stored", 32'(frames_stored), 1);
        chk("rel_frame_avail",   32'(frame_avail),   1);
        do_read(7, 1'b0, 107, 107, 106, 1'b0);
        do_read(3, 1'b0, 103, 103, 102, 1'b0);

        // Frame D refills the released bank while B is being read
        write_frame(400, 64, 1'b0);
        chk("bd_frames_stored", 32'(frames_stored), 2);
        chk("bd_wr_ready",      32'(wr_ready),      0);
        do_release();
        chk("d_frames_stored", 32'(frames_stored), 1);
        chk("d_frame_avail",   32'(frame_avail),   1);
        do_read(0, 1'b1, 463, 400, 463, 1'b0);
        do_read(0, 1'b0, 400, 400, 463, 1'b0);
        do_release();
        chk("empty_frames_stored", 32'(frames_stored), 0);
        chk("empty_frame_avail",   32'(frame_avail),   0);
        chk("empty_wr_ready",      32'(wr_ready),      1);

        // Extra release and read with nothing stored: no effect, rd_data holds
        do_release();
        chk("noop_rel_frames_stored", 32'(frames_stored), 0);
        @(negedge clk);
        rd_req = 1'b1;
        rd_idx = AW'(9);
        @(negedge clk);
        rd_req = 1'b0;
        chk("noop_read_rd_valid", 32'(rd_valid), 0);
        chk("noop_read_rd_data",  32'(rd_data),  400);
`ifdef COLPARITY_FB_DUAL_RD_EN
        chk("noop_read_rd_data_nb", 32'(rd_data_nb), 463);
`endif

        // Reset after slice 30 of a frame discards it
        write_frame(200, 31, 1'b0);
        chk("partial_frame_avail", 32'(frame_avail), 0);
        rst = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge clk);
        rst = 1'b1;

        // Next frame must start at slice 0
        write_frame(300, 64, 1'b1);
        chk("post_frames_stored", 32'(frames_stored), 1);
        do_read(0,  1'b0, 300, 300, 363, 1'b0);
        do_read(30, 1'b0, 330, 330, 329, 1'b0);
        do_read(31, 1'b1, 330, 331, 330, 1'b0);

        repeat (3) @(negedge clk);
        chk("pending_reads", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_frame_buffer.md
# slice_frame_buffer

Synthesizable double-buffered store for Keccak-style state frames, organised as DEPTH slices of W bits (default 64 × 25-bit column-parity slices). A producer streams one frame slice by slice into the write bank while the theta/column-parity datapath reads the other bank by slice index, including the wrapped neighbour slice (z−1 mod DEPTH). It replaces file-based slice loading in the column-parity path with a synthesizable block that also supports ping-pong operation.

## Interface
- W, 25, slice width in bits
- DEPTH, 64, slices per frame; power of two, ≥ 2
- AW, $clog2(DEPTH), slice index width (derived)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- wr_valid  in  1  slice present on wr_data
- wr_ready  out  1  write bank can accept a slice
- wr_data  in  W  slice value
- rd_req  in  1  read request for slice rd_idx of the read bank
- rd_sel  in  1  0: slice rd_idx; 1: neighbour slice (rd_idx−1) mod DEPTH
- rd_idx  in  AW  slice index
- rd_release  in  1  pulse: reader done with the current read bank
- rd_valid  out  1  rd_data updated this cycle
- rd_data  out  W  selected slice
- rd_data_nb  out  W  neighbour slice; only with COLPARITY_FB_DUAL_RD_EN
- frame_avail  out  1  read bank holds a complete frame
- frames_stored  out  2  complete frames held (0..2)

## Operation
- Two banks of DEPTH×W. Per-bank `full` flag, write-bank pointer wb, read-bank pointer rb, write slice counter wr_ptr (AW bits).
- Write accept: wr_valid && wr_ready, with wr_ready = !full[wb]. Slice stored at bank wb, address wr_ptr; wr_ptr increments.
- After accepting the slice at wr_ptr = DEPTH−1: full[wb] set, wb toggles, wr_ptr wraps to 0. Slices arrive strictly in index order 0..DEPTH−1.
- frame_avail = full[rb]. frames_stored = full[0] + full[1].
- Read: rd_req && frame_avail. Address = rd_idx if rd_sel = 0, else (rd_idx − 1) mod DEPTH, computed in AW bits so index 0 maps to DEPTH−1.
- rd_req while !frame_avail is ignored: rd_valid stays 0 and rd_data holds its value.
- rd_release && full[rb]: full[rb] cleared, rb toggles. rd_release while !full[rb] is ignored.
- Bank-state FSM, per bank: EMPTY → FILLING (first accepted slice) → FULL (last slice) → EMPTY (release). A bank is never written while FULL.

## Timing
- Reset (rst low, asynchronous): both `full` flags = 0, wb = rb = 0, wr_ptr = 0, rd_valid = 0, rd_data = 0, rd_data_nb = 0, frame_avail = 0, frames_stored = 0, wr_ready = 1. Bank contents are not cleared.
- Reset asserted mid-frame discards the partial frame and all stored frames.
- Write: single-cycle accept. The completing write sets full on the next edge. frame_avail rises 1 cycle after the last accept when wb equalled rb.
- Read latency: 1 cycle. rd_data and rd_valid are registered. Back-to-back reads are allowed every cycle.
- rd_req and rd_release in the same cycle: the read is served from the old rb, then the release takes effect. rd_valid = 1 next cycle with the old-bank data.
- Last write into bank X and release of bank Y in the same cycle: both take effect. Writing into the bank being released is impossible, because that bank is FULL.
- Both banks full: wr_ready = 0 until the cycle after rd_release.

## Configuration
- COLPARITY_FB_DUAL_RD_EN defined: second read port. On each served read, rd_data_nb = slice (rd_idx−1) mod DEPTH and rd_data = slice rd_idx; rd_sel is ignored. Same 1-cycle latency, same rd_valid.
- COLPARITY_FB_DUAL_RD_EN undefined: rd_data_nb port is absent. A single read port is muxed by rd_sel.

## Structure
- Shared package colparity_pkg holds:
  - W/DEPTH defaults
  - bank-state enum {EMPTY, FILLING, FULL}
  - wrap-decrement helper function
- One sub-module: slice_bank_ram (DEPTH×W, one synchronous write port, one or two registered read ports), instantiated twice.

## Test plan
- Reset then write 64 slices, slice i = i: frame_avail rises 1 cycle after the 64th accept. Read idx 5, rd_sel = 0 → rd_data = 5 one cycle later.
- Wrap: after a full frame, read idx 0 with rd_sel = 1 → 63. With DUAL_RD_EN: rd_data = 0, rd_data_nb = 63.
- Ping-pong: write frame A (i), then frame B (i+100). frames_stored = 2, wr_ready = 0. Read idx 3 → 3. rd_release, then read idx 3 → 103. wr_ready = 1 in the cycle after release.
- Same-cycle rd_req idx 7 + rd_release with both banks full → rd_data = 7 (old bank). Next read idx 7 → 107.
- rd_req with no complete frame, and rd_release with no frame: rd_valid stays 0, no state change.
- Assert rst after slice 30 of a frame: all outputs return to reset values, wr_ready = 1. The next frame starts at slice 0.
